// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard_unit
//  Purpose  : Decode-stage hazard scoreboard: forwarding select, load-use and
//             MULT/DIV R0 stall. Optional R0 tracking: HAZ_MULDIV_TRACK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_unit #(
   parameter  int NUM_REGS    = 16,
   parameter  int TRACK_DEPTH = 2,
   parameter  int MULDIV_LAT  = 4,
   localparam int RW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          id_valid,
   input  logic          flush,
   input  logic [RW-1:0] id_src1,
   input  logic [RW-1:0] id_src2,
   input  logic          id_src1_en,
   input  logic          id_src2_en,
   input  logic [RW-1:0] id_dst,
   input  logic          id_dst_en,
   input  logic          id_is_load,
   input  logic          id_is_muldiv,
   input  logic          id_reads_r0,
   output logic          stall,
   output logic [2:0]    fwd_sel1,
   output logic [2:0]    fwd_sel2,
   output logic          r0_busy
);

   logic [TRACK_DEPTH-1:0]         r_valid;
   logic [TRACK_DEPTH-1:0]         r_load;
   logic [TRACK_DEPTH-1:0][RW-1:0] r_dst;

   logic w_load_use;
   logic w_r0_hazard;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid[0] <= 1'b0;
         r_load[0]  <= 1'b0;
         r_dst[0]   <= '0;
      end else begin
         r_valid[0] <= !flush && id_valid && id_dst_en && !stall;
         r_load[0]  <= id_is_load;
         r_dst[0]   <= id_dst;
      end
   end

   generate
      for (genvar k = 1; k < TRACK_DEPTH; k++) begin : g_shift
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_valid[k] <= 1'b0;
               r_load[k]  <= 1'b0;
               r_dst[k]   <= '0;
            end else begin
               r_valid[k] <= !flush && r_valid[k-1];
               r_load[k]  <= r_load[k-1];
               r_dst[k]   <= r_dst[k-1];
            end
         end
      end
   endgenerate

   // Scan oldest to youngest so the youngest matching writer overrides.
   always_comb begin
      fwd_sel1 = 3'd0;
      fwd_sel2 = 3'd0;
      for (int k = TRACK_DEPTH - 1; k >= 0; k--) begin
         if (r_valid[k] && id_src1_en && (r_dst[k] == id_src1)) fwd_sel1 = 3'(k + 1);
         if (r_valid[k] && id_src2_en && (r_dst[k] == id_src2)) fwd_sel2 = 3'(k + 1);
      end
   end

   assign w_load_use = r_valid[0] && r_load[0] &&
                       ((id_src1_en && (r_dst[0] == id_src1)) ||
                        (id_src2_en && (r_dst[0] == id_src2)));

`ifdef HAZ_MULDIV_TRACK_EN
   logic [3:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 r_cnt <= 4'd0;
      else if (flush)                             r_cnt <= 4'd0;
      else if (id_valid && id_is_muldiv && !stall) r_cnt <= 4'(MULDIV_LAT - 1);
      else if (r_cnt != 4'd0)                     r_cnt <= r_cnt - 4'd1;
   end

   assign r0_busy     = (r_cnt != 4'd0);
   assign w_r0_hazard = r0_busy &&
                        (id_reads_r0 || id_is_muldiv ||
                         (id_src1_en && (id_src1 == '0)) ||
                         (id_src2_en && (id_src2 == '0)) ||
                         (id_dst_en  && (id_dst  == '0)));
`else
   logic w_unused;
   assign w_unused    = &{1'b0, id_reads_r0, id_is_muldiv};
   assign r0_busy     = 1'b0;
   assign w_r0_hazard = 1'b0;
`endif

   assign stall = id_valid && (w_load_use || w_r0_hazard);

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (32'(fwd_sel1) <= TRACK_DEPTH) else $error("fwd_sel1 out of range: %0d", fwd_sel1);
         assert (32'(fwd_sel2) <= TRACK_DEPTH) else $error("fwd_sel2 out of range: %0d", fwd_sel2);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard_unit
//  Purpose  : Directed self-checking bench for hazard_scoreboard_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, flush;
   logic [3:0] id_src1, id_src2, id_dst;
   logic       id_src1_en, id_src2_en, id_dst_en;
   logic       id_is_load, id_is_muldiv, id_reads_r0;
   logic       stall, r0_busy;
   logic [2:0] fwd_sel1, fwd_sel2;

   int total = 0;
   int bad   = 0;

   hazard_scoreboard_unit dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .flush(flush),
      .id_src1(id_src1), .id_src2(id_src2), .id_src1_en(id_src1_en), .id_src2_en(id_src2_en),
      .id_dst(id_dst), .id_dst_en(id_dst_en), .id_is_load(id_is_load),
      .id_is_muldiv(id_is_muldiv), .id_reads_r0(id_reads_r0),
      .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .r0_busy(r0_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // valid, src1, src1_en, src2, src2_en, dst, dst_en, load, muldiv, reads_r0
   task automatic drive(input logic v, input logic [3:0] s1, input logic e1,
                        input logic [3:0] s2, input logic e2, input logic [3:0] d,
                        input logic de, input logic ld, input logic md, input logic r0);
      id_valid = v;  id_src1 = s1; id_src1_en = e1; id_src2 = s2; id_src2_en = e2;
      id_dst = d;    id_dst_en = de; id_is_load = ld; id_is_muldiv = md; id_reads_r0 = r0;
   endtask

   task automatic bubble();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Advance one clock; inputs change and outputs settle 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      flush = 0;
      bubble();
      rst_n = 0;
      #3;
      check("rst_stall", {3'b0, stall}, 0);
      check("rst_sel1", {1'b0, fwd_sel1}, 0);
      check("rst_sel2", {1'b0, fwd_sel2}, 0);
      check("rst_busy", {3'b0, r0_busy}, 0);
      #4 rst_n = 1;
      tick();

      // Producer then consumer: entry 0, then entry 1
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);            // ADD r3
      #3 check("add_r3_stall", {3'b0, stall}, 0);
      tick();
      drive(1, 3, 1, 1, 1, 5, 1, 0, 0, 0);            // ADD r5,r3,r1
      #3 check("fwd_e0_sel1", {1'b0, fwd_sel1}, 1);
      check("fwd_e0_sel2", {1'b0, fwd_sel2}, 0);
      check("fwd_e0_stall", {3'b0, stall}, 0);
      tick();
      drive(1, 3, 1, 5, 1, 7, 1, 0, 0, 0);            // ADD r7,r3,r5
      #3 check("fwd_e1_sel1", {1'b0, fwd_sel1}, 2);
      check("fwd_e1_sel2", {1'b0, fwd_sel2}, 1);
      tick();
      bubble(); tick(); bubble(); tick();

      // Writer older than the tracking window is no longer forwarded
      drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);            // ADD r8
      tick(); bubble(); tick(); bubble(); tick();
      drive(1, 8, 1, 0, 0, 9, 1, 0, 0, 0);
      #3 check("fwd_aged_out", {1'b0, fwd_sel1}, 0);
      tick(); bubble(); tick(); bubble(); tick();

      // Load-use: one bubble, then forward from entry 1
      drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);            // LW r4
      #3 check("lw_stall", {3'b0, stall}, 0);
      tick();
      drive(1, 4, 1, 0, 0, 6, 1, 0, 0, 0);            // ADD r6,r4
      #3 check("lu_stall", {3'b0, stall}, 1);
      check("lu_sel1", {1'b0, fwd_sel1}, 1);
      tick();
      #3 check("lu_after_stall", {3'b0, stall}, 0);
      check("lu_after_sel1", {1'b0, fwd_sel1}, 2);
      tick(); bubble(); tick(); bubble(); tick();

      // Load-use on src2 with a disabled src1 match
      drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
      tick();
      drive(1, 4, 0, 4, 1, 0, 0, 0, 0, 0);
      #3 check("lu_src2_stall", {3'b0, stall}, 1);
      check("lu_src1_dis", {1'b0, fwd_sel1}, 0);
      drive(0, 4, 1, 0, 0, 0, 0, 0, 0, 0);            // invalid decode never stalls
      #1 check("lu_invalid_stall", {3'b0, stall}, 0);
      check("lu_invalid_sel1", {1'b0, fwd_sel1}, 1);
      tick(); bubble(); tick(); bubble(); tick();

      // Youngest writer wins
      drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); tick();    // ADD r2
      drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); tick();    // ADD r2
      drive(1, 2, 1, 2, 1, 0, 0, 0, 0, 0);            // SW r2,(r2)
      #3 check("young_sel1", {1'b0, fwd_sel1}, 1);
      check("young_sel2", {1'b0, fwd_sel2}, 1);
      tick(); bubble(); tick(); bubble(); tick();

      // Flush discards a tracked load
      drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); tick();    // LW r4
      bubble(); flush = 1; tick(); flush = 0;
      drive(1, 4, 1, 0, 0, 6, 1, 0, 0, 0);
      #3 check("flush_stall", {3'b0, stall}, 0);
      check("flush_sel1", {1'b0, fwd_sel1}, 0);
      tick(); bubble(); tick();

      // MULT then BE reading R0
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);            // MULT
      #3 check("mult_stall", {3'b0, stall}, 0);
      check("mult_busy0", {3'b0, r0_busy}, 0);
      tick();
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);            // BE
`ifdef HAZ_MULDIV_TRACK_EN
      for (int i = 0; i < 3; i++) begin
         #3 check($sformatf("md_stall%0d", i), {3'b0, stall}, 1);
         check($sformatf("md_busy%0d", i), {3'b0, r0_busy}, 1);
         tick();
      end
`endif
      #3 check("md_release_stall", {3'b0, stall}, 0);
      check("md_release_busy", {3'b0, r0_busy}, 0);
      tick(); bubble(); tick();

      // Reset between edges during MULT
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();    // MULT
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);            // BE
`ifdef HAZ_MULDIV_TRACK_EN
      #2 check("pre_rst_stall", {3'b0, stall}, 1);
      check("pre_rst_busy", {3'b0, r0_busy}, 1);
      #1 rst_n = 0;
`else
      #3 rst_n = 0;
`endif
      #1 check("async_rst_busy", {3'b0, r0_busy}, 0);
      check("async_rst_stall", {3'b0, stall}, 0);
      #2 rst_n = 1;
      tick();
      #3 check("post_rst_stall", {3'b0, stall}, 0);
      check("post_rst_busy", {3'b0, r0_busy}, 0);
      tick(); bubble(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      bad++;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, meaning the architectural register count; register index width RW = $clog2(NUM_REGS).
REQ-002 SHALL have parameter TRACK_DEPTH, default 2 (legal 1..4), meaning the number of in-flight writer stages tracked after decode (entry 0 = s2, entry 1 = s3, ...).
REQ-003 SHALL have parameter MULDIV_LAT, default 4 (legal 2..15), meaning the number of cycles MULT/DIV occupies R0 before its result is forwardable.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have ports id_valid (in, 1, decode slot holds an instruction) and flush (in, 1, discard all tracked writers).
REQ-007 SHALL have ports id_src1/id_src2 (in, RW, source registers) and id_src1_en/id_src2_en (in, 1, source read enables).
REQ-008 SHALL have ports id_dst (in, RW, destination register), id_dst_en (in, 1, instruction writes id_dst), id_is_load (in, 1, writer is LW), id_is_muldiv (in, 1, MULT/DIV writing implicit R0) and id_reads_r0 (in, 1, branch/implicit R0 read).
REQ-009 SHALL have outputs stall (1, hold decode and insert a bubble), fwd_sel1/fwd_sel2 (3 bits each, 0 = register file, k+1 = forward from entry k) and r0_busy (1, MULT/DIV in progress).

Function
REQ-010 SHALL hold a shift array of TRACK_DEPTH entries {valid, dst, is_load}; each cycle entry k moves to k+1 and the oldest entry is dropped.
REQ-011 SHALL write entry 0 with {id_valid & id_dst_en & !stall, id_dst, id_is_load}; a stalled or invalid decode inserts a bubble (valid = 0).
REQ-012 SHALL drive fwd_selN to k+1 for the lowest k whose valid entry dst equals id_srcN with id_srcN_en = 1; otherwise 0 (youngest writer wins).
REQ-013 SHALL assert stall combinationally when an enabled source matches entry 0 with is_load = 1 (load-use); exactly one bubble results, after which the match is at entry 1 and is forwarded.
REQ-014 SHALL, when id_valid & id_is_muldiv & !stall, load a down-counter with MULDIV_LAT-1; counter decrements by 1 per cycle to 0 and r0_busy = (counter != 0).
REQ-015 SHALL assert stall while r0_busy = 1 and the decode instruction has id_reads_r0, id_is_muldiv, or an enabled source or id_dst equal to 0.
REQ-016 SHALL treat stall as the OR of REQ-013 and REQ-015; stall SHALL be 0 whenever id_valid = 0.
REQ-017 SHALL, on flush = 1, clear all entry valid bits and the counter at the next edge; flush takes priority over a simultaneous insert or muldiv load.
REQ-018 SHALL assert that fwd_sel1 and fwd_sel2 never exceed TRACK_DEPTH (simulation only).

Reset
REQ-019 SHALL, while rst_n = 0, clear all entry valid bits and the counter immediately, independent of clk, giving stall = 0, fwd_sel1 = fwd_sel2 = 0, r0_busy = 0.
REQ-020 SHALL resume tracking at the first rising edge after rst_n deasserts; an in-flight MULT/DIV interrupted by reset is discarded.

Configuration
REQ-021 SHALL, with HAZ_MULDIV_TRACK_EN defined, implement REQ-014 and REQ-015; without it, the counter is not built, r0_busy is tied 0 and stall comes from REQ-013 only.

Verification
REQ-022 ADD r3 then ADD r5,r3 next cycle -> fwd_sel1 = 1, stall = 0; same consumer one cycle later -> fwd_sel1 = 2.
REQ-023 LW r4 then ADD r6,r4 -> stall = 1 for exactly one cycle, then fwd_sel1 = 2 with stall = 0.
REQ-024 ADD r2, ADD r2, then SW reading r2 -> fwd_sel = 1 (youngest), not 2.
REQ-025 MULT with MULDIV_LAT = 4 then BE (id_reads_r0) -> stall for 3 cycles, r0_busy falls with stall; repeat without HAZ_MULDIV_TRACK_EN -> no stall.
REQ-026 LW r4 followed by flush, then ADD reading r4 -> stall = 0, fwd_sel1 = 0.
REQ-027 rst_n low mid-MULT between edges -> r0_busy and stall drop to 0 before the next clk edge.
